// File: rtl/mem_resp_pkg.sv
// Shared constants for the mem_resp data-side responder: MMIO register map,
// STATUS bit positions, store size masks and the lane-shift helper.
package mem_resp_pkg;

  localparam logic [31:0] MMIO_SIZE = 32'd32;

  localparam logic [4:0] OFF_TX_DATA  = 5'h00;
  localparam logic [4:0] OFF_STATUS   = 5'h04;
  localparam logic [4:0] OFF_CYCLE_LO = 5'h08;
  localparam logic [4:0] OFF_CYCLE_HI = 5'h0C;
  localparam logic [4:0] OFF_EXIT     = 5'h10;

  localparam int unsigned STAT_EMPTY = 0;
  localparam int unsigned STAT_FULL  = 1;
  localparam int unsigned STAT_OVF   = 2;

  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0011;
  localparam logic [3:0] SZ_W = 4'b1111;

  // Lanes shifted past lane 3 fall off; nothing wraps into the next word.
  function automatic logic [3:0] shift_mask(input logic [3:0] m, input logic [1:0] sh);
    logic [7:0] t;
    t = {4'b0000, m} << sh;
    return t[3:0];
  endfunction

endpackage

// File: rtl/mem_resp_tx_fifo.sv
// Console TX byte FIFO: extra-MSB pointers, push accepted when full if a pop
// happens in the same cycle, head forced to zero while empty.
module tx_fifo
  import mem_resp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             push_drop
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [PW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok_s, pop_ok_s;

  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign push_drop = push && full && !pop_ok_s;
  assign head      = empty ? {WIDTH{1'b0}} : mem_q[rd_q[PW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok_s) begin
      wr_d = wr_q + PTR_ONE;
    end else begin
      wr_d = wr_q;
    end
    if (pop_ok_s) begin
      rd_d = rd_q + PTR_ONE;
    end else begin
      rd_d = rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && push_ok_s) begin
      mem_q[wr_q[PW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/mem_resp.sv
// Data RAM plus MMIO window (TX FIFO, STATUS, cycle counter, EXIT) for the
// single-cycle core. Define MEM_RESP_COUNTER_EN to build the 64-bit counter.
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_din,
  input  logic [XLEN/8-1:0] mem_w,
  input  logic              mem_r,
  output logic [XLEN-1:0]   mem_dout,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              exit_valid,
  output logic [XLEN-1:0]   exit_code,
  output logic              bus_err
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  logic [1:0]      sh_s;
  logic [AW-1:0]   ram_idx_s;
  logic            in_ram_s, in_mmio_s, unmapped_s;
  logic [31:0]     mmio_off_s;
  logic [4:0]      reg_off_s;
  logic            store_s;
  logic [3:0]      wmask_sh_s;
  logic [31:0]     wdata_sh_s;
  logic [31:0]     rd_word_s;
  logic            tx_push_s, tx_pop_s, push_drop_s, fifo_empty_s, fifo_full_s;
  logic            status_wr_s, exit_wr_s;

  logic [31:0]     ram_q [RAM_WORDS];
  logic            overflow_q, overflow_d;
  logic            exit_valid_q, exit_valid_d;
  logic [31:0]     exit_code_q, exit_code_d;
  logic            bus_err_q, bus_err_d;

  assign sh_s       = mem_addr[1:0];
  assign ram_idx_s  = mem_addr[AW+1:2];
  assign in_ram_s   = (mem_addr[31:AW+2] == '0);
  assign mmio_off_s = mem_addr - MMIO_BASE;
  assign in_mmio_s  = !in_ram_s && (mmio_off_s < MMIO_SIZE);
  assign unmapped_s = !in_ram_s && !in_mmio_s;
  assign reg_off_s  = {mmio_off_s[4:2], 2'b00};

  // Reset cycles suppress every store side effect.
  assign store_s    = rstn && (mem_w != 4'b0000);
  assign wmask_sh_s = shift_mask(mem_w, sh_s);
  assign wdata_sh_s = mem_din << {sh_s, 3'b000};

  assign tx_push_s   = store_s && in_mmio_s && (reg_off_s == OFF_TX_DATA) && wmask_sh_s[0];
  assign status_wr_s = store_s && in_mmio_s && (reg_off_s == OFF_STATUS);
  assign exit_wr_s   = store_s && in_mmio_s && (reg_off_s == OFF_EXIT);
  assign tx_pop_s    = tx_valid && tx_ready;
  assign tx_valid    = !fifo_empty_s;

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (tx_push_s),
    .push_data (mem_din[7:0]),
    .pop       (tx_pop_s),
    .head      (tx_data),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s),
    .push_drop (push_drop_s)
  );

  // Byte-lane RAM write; contents survive reset.
  always_ff @(posedge clk) begin
    if (store_s && in_ram_s) begin
      for (int l = 0; l < 4; l++) begin
        if (wmask_sh_s[l]) begin
          ram_q[ram_idx_s][8*l +: 8] <= wdata_sh_s[8*l +: 8];
        end
      end
    end
  end

`ifdef MEM_RESP_COUNTER_EN
  logic [63:0] cycle_q;
  logic [31:0] hi_shadow_q;

  // Free-running counter; a CYCLE_LO load snapshots the upper half.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cycle_q     <= 64'd0;
      hi_shadow_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (mem_r && in_mmio_s && (reg_off_s == OFF_CYCLE_LO)) begin
        hi_shadow_q <= cycle_q[63:32];
      end else begin
        hi_shadow_q <= hi_shadow_q;
      end
    end
  end
`endif

  always_comb begin
    overflow_d   = overflow_q;
    exit_valid_d = exit_valid_q;
    exit_code_d  = exit_code_q;
    bus_err_d    = unmapped_s && (mem_r || (mem_w != 4'b0000));
    if (push_drop_s) begin
      overflow_d = 1'b1;
    end else if (status_wr_s) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (exit_wr_s && !exit_valid_q) begin
      exit_valid_d = 1'b1;
      exit_code_d  = mem_din;
    end else begin
      exit_valid_d = exit_valid_q;
      exit_code_d  = exit_code_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow_q   <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_code_q  <= 32'd0;
      bus_err_q    <= 1'b0;
    end else begin
      overflow_q   <= overflow_d;
      exit_valid_q <= exit_valid_d;
      exit_code_q  <= exit_code_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // Combinational read word, right-aligned to the addressed byte.
  always_comb begin
    rd_word_s = 32'd0;
    if (in_ram_s) begin
      rd_word_s = ram_q[ram_idx_s];
    end else if (in_mmio_s) begin
      case (reg_off_s)
        OFF_STATUS:   rd_word_s = {29'd0, overflow_q, fifo_full_s, fifo_empty_s};
`ifdef MEM_RESP_COUNTER_EN
        OFF_CYCLE_LO: rd_word_s = cycle_q[31:0];
        OFF_CYCLE_HI: rd_word_s = hi_shadow_q;
`endif
        default:      rd_word_s = 32'd0;
      endcase
    end else begin
      rd_word_s = 32'd0;
    end
  end

  assign mem_dout   = rd_word_s >> {sh_s, 3'b000};
  assign exit_valid = exit_valid_q;
  assign exit_code  = exit_code_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp: RAM lane alignment, TX FIFO overflow and
// simultaneous push/pop, EXIT stickiness, bus errors, mid-run reset.
module tb_mem_resp;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] mem_addr, mem_din, mem_dout, exit_code;
  logic [3:0]  mem_w;
  logic        mem_r, tx_valid, tx_ready, exit_valid, bus_err;
  logic [7:0]  tx_data;

  int vectors = 0;
  int miscompares = 0;

  mem_resp dut (
    .clk        (clk),
    .rstn       (rstn),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_w      (mem_w),
    .mem_r      (mem_r),
    .mem_dout   (mem_dout),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .exit_valid (exit_valid),
    .exit_code  (exit_code),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_addr = 32'd0;
    mem_din  = 32'd0;
    mem_w    = 4'b0000;
    mem_r    = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    mem_addr = a;
    mem_din  = d;
    mem_w    = m;
    mem_r    = 1'b0;
    tick();
    idle();
    #1;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    mem_addr = a;
    mem_w    = 4'b0000;
    #1;
    chk(tag, mem_dout, exp);
  endtask

  initial begin
    idle();
    tx_ready = 1'b0;
    rstn     = 1'b0;
    tick();
    tick();
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_exit_valid", {31'd0, exit_valid}, 32'd0);
    chk("rst_exit_code", exit_code, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    load_chk("rst_status", BASE + 32'h4, 32'h1);
    rstn = 1'b1;
    idle();
    #1;

    // RAM lane alignment
    store(32'h100, 32'hDEAD_BEEF, 4'b1111);
    load_chk("lw_full", 32'h100, 32'hDEAD_BEEF);
    store(32'h102, 32'h0000_00AA, 4'b0001);
    load_chk("lw_after_sb", 32'h100, 32'hDEAA_BEEF);
    load_chk("lbu_103", 32'h103, 32'h0000_00DE);
    store(32'h103, 32'h0000_1234, 4'b0011);
    load_chk("lw_after_sh_drop", 32'h100, 32'h34AA_BEEF);
    load_chk("lhu_101", 32'h101, 32'h0034_AABE);

    // Read in the store cycle sees the old word
    mem_addr = 32'h100;
    mem_din  = 32'h1111_1111;
    mem_w    = 4'b1111;
    #1;
    chk("same_cycle_old", mem_dout, 32'h34AA_BEEF);
    tick();
    idle();
    load_chk("after_store_new", 32'h100, 32'h1111_1111);

    // FIFO overflow with sink stalled
    tx_ready = 1'b0;
    store(BASE, 32'h41, 4'b0001);
    chk("push_raises_valid", {31'd0, tx_valid}, 32'd1);
    for (int i = 1; i < 9; i++) begin
      store(BASE, 32'h41 + i, 4'b0001);
    end
    load_chk("status_ovf_full", BASE + 32'h4, 32'h6);
    chk("ovf_tx_valid", {31'd0, tx_valid}, 32'd1);
    chk("ovf_tx_data", {24'd0, tx_data}, 32'h41);
    load_chk("tx_data_reg_reads0", BASE, 32'h0);
    idle();
    tx_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", {31'd0, tx_valid}, 32'd1);
      chk("drain_data", {24'd0, tx_data}, 32'h41 + i);
      tick();
    end
    chk("drained_valid", {31'd0, tx_valid}, 32'd0);
    chk("drained_data", {24'd0, tx_data}, 32'd0);
    tx_ready = 1'b0;
    store(BASE + 32'h4, 32'h0, 4'b1111);
    load_chk("status_ovf_clr", BASE + 32'h4, 32'h1);

    // Push into a full FIFO while popping
    for (int i = 0; i < 8; i++) begin
      store(BASE, 32'h50 + i, 4'b0001);
    end
    load_chk("status_full", BASE + 32'h4, 32'h2);
    tx_ready = 1'b1;
    mem_addr = BASE;
    mem_din  = 32'h58;
    mem_w    = 4'b0001;
    tick();
    idle();
    tx_ready = 1'b0;
    load_chk("full_push_pop_status", BASE + 32'h4, 32'h2);
    chk("full_push_pop_head", {24'd0, tx_data}, 32'h51);
    tx_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("drain2_data", {24'd0, tx_data}, 32'h51 + i);
      tick();
    end
    chk("drain2_empty", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // EXIT is write-once
    store(BASE + 32'h10, 32'd7, 4'b1111);
    chk("exit_valid_set", {31'd0, exit_valid}, 32'd1);
    store(BASE + 32'h10, 32'd9, 4'b1111);
    chk("exit_code_sticky", exit_code, 32'd7);

    // Unmapped and reserved accesses
    mem_addr = 32'h4000_0000;
    mem_r    = 1'b1;
    #1;
    chk("unmapped_dout", mem_dout, 32'd0);
    chk("bus_err_before", {31'd0, bus_err}, 32'd0);
    tick();
    idle();
    #1;
    chk("bus_err_pulse", {31'd0, bus_err}, 32'd1);
    tick();
    chk("bus_err_one_cycle", {31'd0, bus_err}, 32'd0);
    store(BASE + 32'h14, 32'hFFFF_FFFF, 4'b1111);
    chk("reserved_no_err", {31'd0, bus_err}, 32'd0);
    load_chk("reserved_read0", BASE + 32'h14, 32'd0);

`ifndef MEM_RESP_COUNTER_EN
    mem_r = 1'b1;
    load_chk("cycle_lo_absent", BASE + 32'h8, 32'd0);
    tick();
    idle();
    #1;
    chk("cycle_lo_no_err", {31'd0, bus_err}, 32'd0);
`endif

    // Mid-run reset with a byte queued
    store(BASE, 32'h77, 4'b0001);
    chk("pre_reset_valid", {31'd0, tx_valid}, 32'd1);
    rstn     = 1'b0;
    mem_addr = 32'h100;
    mem_din  = 32'hBAD0_BAD0;
    mem_w    = 4'b1111;
    tick();
    idle();
    #1;
    chk("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("midrst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("midrst_exit_valid", {31'd0, exit_valid}, 32'd0);
    chk("midrst_exit_code", exit_code, 32'd0);
`ifdef MEM_RESP_COUNTER_EN
    load_chk("midrst_cycle_lo", BASE + 32'h8, 32'd0);
`endif
    rstn = 1'b1;
    load_chk("ram_survives_reset", 32'h100, 32'h1111_1111);
`ifdef MEM_RESP_COUNTER_EN
    idle();
    tick();
    tick();
    tick();
    load_chk("cycle_lo_after3", BASE + 32'h8, 32'd3);
    mem_r = 1'b1;
    tick();
    idle();
    load_chk("cycle_hi_shadow", BASE + 32'hC, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_resp.md
# mem_resp

Data-side memory responder for the single-cycle RV32I core: it services the core's `mem_addr`/`mem_din`/`mem_w`/`mem_r`/`mem_dout` port. It holds the data RAM and a small MMIO window:

- console TX FIFO with a valid/ready drain port
- 64-bit cycle counter
- simulation exit register

Reads are combinational so the core can retire loads in one cycle. All state changes occur on the rising clock edge.

## Interface
Parameters:
- `XLEN`, 32, data/address width (only 32 supported)
- `RAM_WORDS`, 1024, RAM depth in words (power of 2); RAM spans bytes 0 .. 4*RAM_WORDS-1
- `MMIO_BASE`, 32'h8000_0000, byte base of MMIO window (32 bytes)
- `FIFO_DEPTH`, 8, TX FIFO entries (power of 2, ≥2)

Ports:
- `clk`  in  1  clock
- `rstn`  in  1  reset; one clock, reset synchronous active-low
- `mem_addr`  in  XLEN  byte address from core
- `mem_din`  in  XLEN  store data, addressed byte in [7:0]
- `mem_w`  in  XLEN/8  store size mask relative to addressed byte (0001 B, 0011 H, 1111 W, 0000 none)
- `mem_r`  in  1  load strobe
- `mem_dout`  out  XLEN  load data, addressed byte in [7:0]
- `tx_data`  out  8  FIFO head byte
- `tx_valid`  out  1  FIFO non-empty
- `tx_ready`  in  1  sink accepts head
- `exit_valid`  out  1  sticky, program wrote EXIT
- `exit_code`  out  XLEN  value written to EXIT
- `bus_err`  out  1  one-cycle pulse, unmapped access

## Operation
Word alignment:
- Word index is `mem_addr[31:2]`; `sh` = `mem_addr[1:0]`.
- Store: mask and `mem_din` are shifted left by `sh` bytes. Lanes pushed past lane 3 are dropped; there is no wrap into the next word.
- Load: `mem_dout` = selected word >> 8*`sh`, zero-filled.
- `mem_dout` is valid regardless of `mem_r`. `mem_r` only qualifies read side effects.

RAM:
- Asynchronous read; byte-lane write on posedge.
- Contents are not reset.

MMIO (offset from `MMIO_BASE`):
- 0x00 TX_DATA
  - Store with shifted lane 0 set pushes `mem_din[7:0]`.
  - If the FIFO is full and no pop occurs this cycle, the byte is dropped and `overflow` is set.
  - Reads return 0.
- 0x04 STATUS
  - Read {29'b0, overflow, full, empty}.
  - Any store clears `overflow`.
- 0x08 CYCLE_LO
  - Read returns counter[31:0].
  - A load (`mem_r`=1) latches counter[63:32] into `hi_shadow` at that edge.
- 0x0C CYCLE_HI
  - Read returns `hi_shadow`.
- 0x10 EXIT
  - First store sets `exit_valid`=1 and `exit_code`=`mem_din` (unshifted).
  - Later stores are ignored until reset.
- 0x14–0x1C read 0; stores ignored; no `bus_err`.

Unmapped addresses (neither RAM nor MMIO):
- Read 0; stores ignored.
- If `mem_r` or `|mem_w`, `bus_err`=1 for the following cycle.

TX FIFO:
- Count ranges 0..FIFO_DEPTH. `empty` = (count==0); `full` = (count==FIFO_DEPTH).
- Pop when `tx_valid && tx_ready`.
- Push and pop in the same cycle: both take effect, count unchanged. This holds when full: the push is accepted, with no overflow.
- Pointers wrap modulo FIFO_DEPTH using an extra MSB.

Counter:
- 64-bit, +1 every cycle out of reset, wraps at 2^64.

## Timing
- Load latency 0: `mem_dout` is combinational from `mem_addr` and the current state.
- Store/push/exit/overflow/counter updates are visible the cycle after the edge.
- Read of a location written in the same cycle returns the old value.
- `tx_data`/`tx_valid` follow the FIFO state registered at the edge. A push into an empty FIFO raises `tx_valid` on the next cycle.
- Reset (`rstn`=0 at posedge), mid-transfer included:
  - FIFO emptied (`tx_valid`=0, `tx_data`=0)
  - `overflow`=0, counter=0, `hi_shadow`=0
  - `exit_valid`=0, `exit_code`=0, `bus_err`=0
  - RAM untouched
  - Stores are ignored during reset cycles.

## Configuration
- `MEM_RESP_COUNTER_EN`:
  - Defined: the counter and `hi_shadow` exist as above.
  - Undefined: no counter registers; CYCLE_LO/CYCLE_HI read 0 and are otherwise treated like reserved offsets (no `bus_err`).

## Structure
- `mem_resp_pkg`:
  - MMIO offsets (`OFF_TX_DATA`, `OFF_STATUS`, `OFF_CYCLE_LO`, `OFF_CYCLE_HI`, `OFF_EXIT`)
  - MMIO window size
  - STATUS bit indices
  - Size-mask constants B/H/W
- Sub-module `tx_fifo`:
  - Parameters: width 8, `FIFO_DEPTH`.
  - Ports: push, push_data, pop, head, empty, full, overflow-qualifying `push_drop`.
- Top level holds the address decode, alignment shifting, RAM, counter and exit logic.

## Test plan
- SW 0xDEADBEEF to 0x100, then LW 0x100 → 0xDEADBEEF. SB 0xAA to 0x102, then LW 0x100 → 0xDEAABEEF. LBU-style read at 0x103 → dout[7:0]=0xDE.
- SH 0x1234 to 0x103 → only lane 3 written (0x34); LW 0x100 → 0x34AABEEF.
- With `tx_ready`=0, push 9 bytes 0x41..0x49 → STATUS=0b110, `tx_valid`=1, `tx_data`=0x41. Then `tx_ready`=1 → 0x41..0x48 drained over 8 cycles, then `tx_valid`=0. Any STATUS store → overflow bit clears.
- FIFO full with `tx_ready`=1 and a push in the same cycle → no overflow; count stays 8.
- Store 7 to EXIT, then 9 → `exit_valid`=1, `exit_code`=7. Load at 0x4000_0000 → `dout`=0, `bus_err` pulses for exactly 1 cycle.
- With `MEM_RESP_COUNTER_EN`: hold reset, release, load CYCLE_LO at cycle N → N. Assert `rstn`=0 for one cycle mid-run → counter reads restart from 0 and `tx_valid`=0.
